// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: shift right/left, parallel load, saturating shift count.
// Optional recirculating shifts when SHREG_ROTATE_EN is defined (w_rot selects rotate vs serial input).
module shift_reg_univ #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_en,
  input  logic [1:0]       w_mode,
  input  logic             w_sin,
  input  logic             w_rot,
  input  logic [WIDTH-1:0] w_pin,
  output logic [WIDTH-1:0] w_pout,
  output logic             w_sout_r,
  output logic             w_sout_l,
  output logic [CNT_W-1:0] w_cnt,
  output logic             w_full
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_r, in_l;
  logic [CNT_W-1:0] cnt_inc;

  // Bit entering on each shift direction: serial input, or the bit leaving at the far end when rotating.
  always_comb begin
    in_r = w_sin;
    in_l = w_sin;
`ifdef SHREG_ROTATE_EN
    if (w_rot) begin
      in_r = s_q[0];
      in_l = s_q[WIDTH-1];
    end
`endif
  end

`ifndef SHREG_ROTATE_EN
  logic unused_rot;
  assign unused_rot = w_rot;
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    s_d   = s_q;
    cnt_d = cnt_q;
    if (w_en) begin
      case (w_mode)
        MODE_HOLD: begin
          s_d   = s_q;
          cnt_d = cnt_q;
        end
        MODE_RIGHT: begin
          s_d   = {in_r, s_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        MODE_LEFT: begin
          s_d   = {s_q[WIDTH-2:0], in_l};
          cnt_d = cnt_inc;
        end
        MODE_LOAD: begin
          s_d   = w_pin;
          cnt_d = '0;
        end
        default: begin
          s_d   = s_q;
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      s_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  assign w_pout   = s_q;
  assign w_sout_r = s_q[0];
  assign w_sout_l = s_q[WIDTH-1];
  assign w_cnt    = cnt_q;
  assign w_full   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed scenarios plus random traffic against an arithmetic reference model.
module tb_shift_reg_univ;

  localparam int unsigned W     = 4;
  localparam int unsigned CW    = $clog2(W + 1);
  localparam logic [W-1:0] RV   = 4'b1010;

  logic          clk = 1'b0;
  logic          rst, en, sin, rot;
  logic [1:0]    mode;
  logic [W-1:0]  pin;
  logic [W-1:0]  pout;
  logic          sout_r, sout_l, full;
  logic [CW-1:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register value as a plain integer, count as a plain integer.
  int m_v   = 0;
  int m_cnt = 0;

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .w_clk(clk), .w_rst(rst), .w_en(en), .w_mode(mode), .w_sin(sin), .w_rot(rot),
    .w_pin(pin), .w_pout(pout), .w_sout_r(sout_r), .w_sout_l(sout_l), .w_cnt(cnt), .w_full(full)
  );

  always #5 clk = ~clk;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [1:0] md,
                            input logic s, input logic ro, input logic [W-1:0] p);
    int modulus;
    int inb;
    bit rot_on;
    modulus = 1 << W;
`ifdef SHREG_ROTATE_EN
    rot_on = ro;
`else
    rot_on = 1'b0;
`endif
    if (r) begin
      m_v   = int'(RV);
      m_cnt = 0;
    end else if (e) begin
      if (md == 2'd1) begin
        inb   = rot_on ? (m_v % 2) : int'(s);
        m_v   = (m_v / 2) + inb * (modulus / 2);
        m_cnt = min_i(m_cnt + 1, W);
      end else if (md == 2'd2) begin
        inb   = rot_on ? (m_v / (modulus / 2)) : int'(s);
        m_v   = (m_v * 2 + inb) % modulus;
        m_cnt = min_i(m_cnt + 1, W);
      end else if (md == 2'd3) begin
        m_v   = int'(p);
        m_cnt = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0]  e_pout;
    logic [CW-1:0] e_cnt;
    e_pout = W'(m_v);
    e_cnt  = CW'(m_cnt);
    n_checks++;
    assert (pout === e_pout) else begin
      n_fail++; $error("FAIL %s pout observed=%b expected=%b", tag, pout, e_pout);
    end
    n_checks++;
    assert (sout_r === 1'(m_v % 2)) else begin
      n_fail++; $error("FAIL %s sout_r observed=%b expected=%0d", tag, sout_r, m_v % 2);
    end
    n_checks++;
    assert (sout_l === 1'(m_v / (1 << (W - 1)))) else begin
      n_fail++; $error("FAIL %s sout_l observed=%b expected=%0d", tag, sout_l, m_v / (1 << (W - 1)));
    end
    n_checks++;
    assert (cnt === e_cnt) else begin
      n_fail++; $error("FAIL %s cnt observed=%0d expected=%0d", tag, cnt, e_cnt);
    end
    n_checks++;
    assert (full === (m_cnt == W)) else begin
      n_fail++; $error("FAIL %s full observed=%b expected=%b", tag, full, (m_cnt == W));
    end
  endtask

  task automatic check_lit(input string tag, input logic [W-1:0] e_pout, input int e_cnt);
    n_checks++;
    assert (pout === e_pout) else begin
      n_fail++; $error("FAIL %s pout observed=%b expected=%b", tag, pout, e_pout);
    end
    n_checks++;
    assert (cnt === CW'(e_cnt)) else begin
      n_fail++; $error("FAIL %s cnt observed=%0d expected=%0d", tag, cnt, e_cnt);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++; $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, advance model alongside the edge, sample 1 time unit later.
  task automatic tick(input string tag, input logic r, input logic e, input logic [1:0] md,
                      input logic s, input logic ro, input logic [W-1:0] p);
    rst = r; en = e; mode = md; sin = s; rot = ro; pin = p;
    @(posedge clk);
    model_step(r, e, md, s, ro, p);
    #1;
    check_model(tag);
  endtask

  logic [W-1:0] rot_exp [4];

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'd0; sin = 1'b0; rot = 1'b0; pin = '0;
    @(negedge clk);

    // Reset, then three disabled edges with arbitrary modes.
    tick("reset", 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 4'b1111);
    check_lit("reset_lit", 4'b1010, 0);
    check_bit("reset_full", full, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick("en0_hold", 1'b0, 1'b0, 2'(i + 1), 1'b1, 1'b0, 4'b0101);
      check_lit("en0_hold_lit", 4'b1010, 0);
    end

    // Predecessor equivalence: clear to zero, then shift ones in from the left.
    tick("load0", 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000);
    tick("sr1", 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000);
    check_lit("sr1_lit", 4'b1000, 1); check_bit("sr1_sout_r", sout_r, 1'b0);
    tick("sr2", 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000);
    check_lit("sr2_lit", 4'b1100, 2); check_bit("sr2_sout_r", sout_r, 1'b0);
    tick("sr3", 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000);
    check_lit("sr3_lit", 4'b1110, 3); check_bit("sr3_full", full, 1'b0);
    tick("sr4", 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000);
    check_lit("sr4_lit", 4'b1111, 4); check_bit("sr4_sout_r", sout_r, 1'b1);
    check_bit("sr4_full", full, 1'b1);

    // Load and left shift.
    tick("load0110", 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0110);
    check_lit("load0110_lit", 4'b0110, 0); check_bit("load_full", full, 1'b0);
    tick("sl1", 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000);
    check_lit("sl1_lit", 4'b1101, 1);
    tick("sl2", 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000);
    check_lit("sl2_lit", 4'b1011, 2); check_bit("sl2_sout_l", sout_l, 1'b1);

    // Saturation, then a load attempt with enable low.
    tick("load1111", 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'b1111);
    for (int i = 0; i < 6; i++) tick("sat_sr", 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000);
    check_lit("sat_lit", 4'b0000, 4); check_bit("sat_full", full, 1'b1);
    tick("en0_load", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 4'b1010);
    check_lit("en0_load_lit", 4'b0000, 4);
    tick("hold_mode", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1111);
    check_lit("hold_mode_lit", 4'b0000, 4);

    // Reset mid-stream wins over a simultaneous load.
    tick("ms_sl1", 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000);
    tick("ms_load", 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0011);
    tick("ms_sl2", 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000);
    tick("ms_sl3", 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000);
    check_lit("ms_pre", 4'b1110, 2);
    tick("ms_rst", 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b1111);
    check_lit("ms_rst_lit", 4'b1010, 0);

    // Rotate request: recirculates only in the rotate build.
`ifdef SHREG_ROTATE_EN
    rot_exp[0] = 4'b0100; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0001; rot_exp[3] = 4'b1000;
`else
    rot_exp[0] = 4'b1100; rot_exp[1] = 4'b1110; rot_exp[2] = 4'b1111; rot_exp[3] = 4'b1111;
`endif
    tick("rot_load", 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      tick("rot_sr", 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0000);
      check_lit("rot_lit", rot_exp[i], i + 1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick("rand", ($urandom_range(0, 24) == 0), 1'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register; next generation of the team's 4-bit serial-in/serial-out shift register.
- Adds the following over that block:
  - configurable width
  - synchronous reset
  - clock enable
  - shift-right, shift-left and parallel-load modes
  - parallel output
  - saturating count of shifted-in bits, with a full flag
- Used as a serializer/deserializer stage between the serial I/O logic and the datapath.

Parameters:
- WIDTH, 4, register width in bits; legal range WIDTH >= 2.
- RESET_VAL, 0, value loaded into the register on reset (WIDTH bits).
- CNT_W, $clog2(WIDTH+1), width of the count output (derived; do not override).

Ports:
- w_clk  input  1  clock; all state updates on posedge.
- w_rst  input  1  synchronous, active-high reset.
- w_en  input  1  clock enable; 0 = hold all state.
- w_mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- w_sin  input  1  serial input bit.
- w_rot  input  1  rotate select. Used only when SHREG_ROTATE_EN is defined; otherwise ignored.
- w_pin  input  WIDTH  parallel load data.
- w_pout  output  WIDTH  register contents, r_s.
- w_sout_r  output  1  r_s[0], the bit leaving on a right shift.
- w_sout_l  output  1  r_s[WIDTH-1], the bit leaving on a left shift.
- w_cnt  output  CNT_W  bits shifted in since the last reset/load; saturates at WIDTH.
- w_full  output  1  1 when w_cnt == WIDTH.

Behaviour:
- State: r_s[WIDTH-1:0] and r_cnt[CNT_W-1:0]. All outputs are direct combinational taps of this state; no output logic on inputs.
- Reset:
  - w_rst=1 at posedge gives r_s <= RESET_VAL and r_cnt <= 0.
  - Reset has priority over w_en and w_mode.
  - Values after reset: w_pout=RESET_VAL, w_sout_r=RESET_VAL[0], w_sout_l=RESET_VAL[WIDTH-1], w_cnt=0, w_full=0.
  - Reset asserted mid-stream discards partial data and count in that same edge.
- Enable: w_rst=0 and w_en=0 means r_s and r_cnt both hold, whatever w_mode is.
- Modes (apply when w_rst=0 and w_en=1):
  - 00 hold: no change to r_s or r_cnt.
  - 01 shift right: r_s <= {w_sin, r_s[WIDTH-1:1]}. This is the same direction as the predecessor block, so its serial-out matches w_sout_r.
  - 10 shift left: r_s <= {r_s[WIDTH-2:0], w_sin}.
  - 11 load: r_s <= w_pin and r_cnt <= 0, in the same cycle.
- Count rules:
  - Each enabled shift (01 or 10) increments r_cnt by 1, saturating at WIDTH; no wrap to 0.
  - Hold leaves r_cnt unchanged.
  - Mixed left/right shifts all count.
- Latency:
  - A value on w_sin shows up on w_pout one edge after the shift.
  - On right shifts, that bit reaches w_sout_r after WIDTH shifts.
  - A parallel load is visible on w_pout one edge later.
- w_full is a decode of r_cnt only. It stays 1 through further shifts and holds until load or reset.

Optional Feature:
- Macro: SHREG_ROTATE_EN.
- Defined: when w_rot=1, shifts recirculate instead of taking w_sin.
  - Shift right: r_s <= {r_s[0], r_s[WIDTH-1:1]}.
  - Shift left: r_s <= {r_s[WIDTH-2:0], r_s[WIDTH-1]}.
  - w_sin is ignored.
  - r_cnt still increments and saturates as for a normal shift.
  - With w_rot=0, behaviour is identical to the macro-undefined build.
- Undefined: w_rot is ignored; all shifts take w_sin.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'b1010, w_rst=1 for one edge, then w_en=0 for 3 edges -> w_pout=1010, w_cnt=0, w_full=0 throughout.
- Predecessor equivalence: WIDTH=4, RESET_VAL=0, mode=01, w_sin=1 constant, 4 edges -> w_pout sequence 1000, 1100, 1110, 1111. w_sout_r first goes 1 after edge 4. w_cnt 1, 2, 3, 4; w_full=1 after edge 4.
- Load and left shift: mode=11 with w_pin=0110 -> w_pout=0110, w_cnt=0. Then mode=10, w_sin=1, 2 edges -> 1101, then 1011; w_sout_l=1; w_cnt=2.
- Saturation and enable: 6 right shifts with w_sin=0 from 1111 -> w_cnt stops at 4, w_pout=0000. Then w_en=0 with mode=11 -> no load; w_cnt stays 4.
- Reset mid-stream: after 2 shifts (w_cnt=2), assert w_rst on the same edge as mode=11 with w_pin=1111 -> w_pout=RESET_VAL, w_cnt=0.
- Rotate (SHREG_ROTATE_EN build): load 1000, then w_rot=1, mode=01, w_sin=1, 4 edges -> 0100, 0010, 0001, 1000. w_cnt=4. Same stimulus in the undefined build -> 1100, 1110, 1111, 1111.
